keypad_matrix_scan: RTL

- Drives the columns of a 4x4 active-low matrix keypad and samples its rows.
- Debounces press and release, then emits a 4-bit key code with a one-cycle valid strobe.
- Sits directly upstream of the seven-segment display stage inside the key-scan top level: col goes out to the keypad, and key_code/key_valid feed the display encoder.
- Key numbering: key = row_index*4 + col_index. Key 1 is row 0 / column 1; key 13 is row 3 / column 1.

---
 rtl/key_scan_pkg.sv | 25 ++
 rtl/key_row_sync.sv | 24 ++
 rtl/keypad_matrix_scan.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/key_scan_pkg.sv
// Shared types and constants for the keypad scan path: FSM states,
// idle patterns and the row-priority helper used when forming a key code.
package key_scan_pkg;

   typedef enum logic [1:0] {
      SCAN      = 2'd0,
      PRESS_DEB = 2'd1,
      HELD      = 2'd2,
      REL_DEB   = 2'd3
   } key_state_e;

   localparam logic [4:0] KEY_NONE = 5'd16;
   localparam logic [3:0] COL_IDLE = 4'b1111;

   // Lowest row index pulled low in an active-low pattern; row 0 wins ties.
   function automatic logic [1:0] lowest_row(input logic [3:0] pat);
      logic [1:0] idx;
      idx = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (!pat[r]) idx = 2'(r);
      end
      return idx;
   endfunction

endpackage

// File: rtl/key_row_sync.sv
// Two-flop synchronizer for the four asynchronous keypad row lines.
// Resets to all-ones so an idle keypad is seen immediately after reset.
module key_row_sync
   import key_scan_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= COL_IDLE;
         q    <= COL_IDLE;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_matrix_scan.sv
// 4x4 active-low keypad scanner with press/release debounce. Emits the
// accepted key as key_code with a one-cycle key_valid; state is exported for observation.
module keypad_matrix_scan
   import key_scan_pkg::*;
#(
   parameter int SCAN_CYCLES = 50_000,
   parameter int DEB_CYCLES  = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down,
   output key_state_e state
);

   localparam int SCAN_W = $clog2(SCAN_CYCLES);
   localparam int DEB_W  = $clog2(DEB_CYCLES);

   localparam logic [SCAN_W-1:0] SCAN_LAST   = SCAN_W'(SCAN_CYCLES - 1);
   localparam logic [SCAN_W-1:0] SCAN_SETTLE = SCAN_W'(2);
   localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEB_CYCLES - 1);

   logic [3:0]        row_s;
   logic [SCAN_W-1:0] scan_cnt, scan_cnt_nxt;
   logic [DEB_W-1:0]  deb_cnt, deb_cnt_nxt;
   logic [1:0]        col_idx, col_idx_nxt;
   logic [3:0]        pat, pat_nxt;
   logic [3:0]        col_nxt;
   logic [3:0]        key_code_nxt;
   logic              key_valid_nxt;
   logic              key_down_nxt;
   key_state_e        state_nxt;
   logic              rows_idle;

   key_row_sync u_row_sync (
      .clk (clk),
      .rst (rst),
      .d   (row),
      .q   (row_s)
   );

   assign rows_idle = (row_s == COL_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SCAN;
         scan_cnt  <= '0;
         deb_cnt   <= '0;
         col_idx   <= 2'd0;
         pat       <= COL_IDLE;
         col       <= 4'b1110;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         key_down  <= 1'b0;
      end else begin
         state     <= state_nxt;
         scan_cnt  <= scan_cnt_nxt;
         deb_cnt   <= deb_cnt_nxt;
         col_idx   <= col_idx_nxt;
         pat       <= pat_nxt;
         col       <= col_nxt;
         key_code  <= key_code_nxt;
         key_valid <= key_valid_nxt;
         key_down  <= key_down_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      scan_cnt_nxt  = scan_cnt;
      deb_cnt_nxt   = deb_cnt;
      col_idx_nxt   = col_idx;
      pat_nxt       = pat;
      key_code_nxt  = key_code;
      key_valid_nxt = 1'b0;
      key_down_nxt  = key_down;

      case (state)
         SCAN: begin
            // The first two counts after a column change still carry rows
            // sampled under the previous column, so they are not trusted.
            if (!rows_idle && (scan_cnt >= SCAN_SETTLE)) begin
               pat_nxt     = row_s;
               deb_cnt_nxt = '0;
               state_nxt   = PRESS_DEB;
            end else if (scan_cnt == SCAN_LAST) begin
               scan_cnt_nxt = '0;
               col_idx_nxt  = col_idx + 2'd1;
            end else begin
               scan_cnt_nxt = scan_cnt + 1'b1;
            end
         end

         PRESS_DEB: begin
            if (rows_idle) begin
               scan_cnt_nxt = '0;
               state_nxt    = SCAN;
            end else if (row_s != pat) begin
               pat_nxt     = row_s;
               deb_cnt_nxt = '0;
            end else if (deb_cnt == DEB_LAST) begin
               key_code_nxt  = {lowest_row(pat), col_idx};
               key_valid_nxt = 1'b1;
               key_down_nxt  = 1'b1;
               state_nxt     = HELD;
            end else begin
               deb_cnt_nxt = deb_cnt + 1'b1;
            end
         end

         HELD: begin
            if (rows_idle) begin
               deb_cnt_nxt = '0;
               state_nxt   = REL_DEB;
            end
         end

         REL_DEB: begin
            if (!rows_idle) begin
               deb_cnt_nxt = '0;
               state_nxt   = HELD;
            end else if (deb_cnt == DEB_LAST) begin
               key_down_nxt = 1'b0;
               scan_cnt_nxt = '0;
               state_nxt    = SCAN;
            end else begin
               deb_cnt_nxt = deb_cnt + 1'b1;
            end
         end

         default: begin
            scan_cnt_nxt = '0;
            state_nxt    = SCAN;
         end
      endcase

      col_nxt = ~(4'b0001 << col_idx_nxt);
   end

endmodule
